// File: rtl/cnn_defs.sv
// Shared CNN definitions: data widths, fully-connected layer sizing, the FC FSM
// state type and a signed saturation helper.
package cnn_defs;

  localparam int unsigned CnnDataWidth = 8;
  localparam int unsigned OfmapWidth   = 2;
  localparam int unsigned OfmapHeight  = 2;

  localparam int unsigned FcInLen    = OfmapWidth * OfmapHeight;
  localparam int unsigned FcOutLen   = 10;
  localparam int unsigned FcFracBits = 0;

  typedef enum logic [1:0] {StIdle, StMac, StDrain, StOut} fc_state_t;

  // Clamp a sign-extended value to the signed range of the given width.
  function automatic logic signed [63:0] sat_signed(input logic signed [63:0] value,
                                                    input int unsigned width);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (width - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (width - 1));
    if (value > hi) return hi;
    if (value < lo) return lo;
    return value;
  endfunction

endpackage

// File: rtl/fc_mac.sv
// Registered signed multiply-accumulate; a bias load restarts the sum.
// acc_next exposes the sum being written so the caller can use it in the same cycle.
module fc_mac #(
  parameter int unsigned DataWidth = 8,
  parameter int unsigned AccWidth  = 19
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       en,
  input  logic                       load_bias,
  input  logic [DataWidth-1:0]       bias,
  input  logic [DataWidth-1:0]       a,
  input  logic [DataWidth-1:0]       b,
  output logic signed [AccWidth-1:0] acc,
  output logic signed [AccWidth-1:0] acc_next
);

  logic signed [2*DataWidth-1:0] prod;
  logic signed [AccWidth-1:0]    prod_ext;
  logic signed [AccWidth-1:0]    bias_ext;
  logic signed [AccWidth-1:0]    acc_q;

  assign prod     = $signed(a) * $signed(b);
  assign prod_ext = {{(AccWidth - 2*DataWidth){prod[2*DataWidth-1]}}, prod};
  assign bias_ext = {{(AccWidth - DataWidth){bias[DataWidth-1]}}, bias};

  always_comb begin
    acc_next = acc_q;
    if (en) begin
      acc_next = (load_bias ? bias_ext : acc_q) + prod_ext;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_next;
    end
  end

  assign acc = acc_q;

endmodule

// File: rtl/fc_layer.sv
// Dense layer: one signed MAC per cycle against external weight/bias ROMs, one
// saturated result per beat. Define FC_RELU_EN to clamp negative results to zero.
module fc_layer
  import cnn_defs::*;
#(
  parameter int unsigned InLen     = FcInLen,
  parameter int unsigned OutLen    = FcOutLen,
  parameter int unsigned DataWidth = CnnDataWidth,
  parameter int unsigned FracBits  = FcFracBits,
  localparam int unsigned AccWidth = 2 * DataWidth + $clog2(InLen) + 1,
  localparam int unsigned KW       = (InLen > 1) ? $clog2(InLen) : 1,
  localparam int unsigned NW       = (OutLen > 1) ? $clog2(OutLen) : 1,
  localparam int unsigned AW       = (InLen * OutLen > 1) ? $clog2(InLen * OutLen) : 1
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic [InLen-1:0][DataWidth-1:0] in_data,
  output logic                            w_en,
  output logic [AW-1:0]                   w_addr,
  input  logic [DataWidth-1:0]            w_data,
  output logic [NW-1:0]                   b_addr,
  input  logic [DataWidth-1:0]            b_data,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [DataWidth-1:0]            out_data,
  output logic [NW-1:0]                   out_idx,
  output logic                            out_last
);

  fc_state_t                      state_q, state_d;
  logic [NW-1:0]                  neuron_q, neuron_d;
  logic [KW-1:0]                  k_q, k_d;
  logic [KW-1:0]                  kd_q;
  logic                           mac_en_q;
  logic [InLen-1:0][DataWidth-1:0] vec_q, vec_d;
  logic [DataWidth-1:0]           out_data_q, out_data_d;

  logic [AW-1:0]                  mac_addr;
  logic signed [AccWidth-1:0]     acc, acc_next, acc_shift;
  logic signed [63:0]             acc_wide, sat_val;

  fc_mac #(
    .DataWidth (DataWidth),
    .AccWidth  (AccWidth)
  ) u_mac (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (mac_en_q),
    .load_bias (kd_q == '0),
    .bias      (b_data),
    .a         (w_data),
    .b         (vec_q[kd_q]),
    .acc       (acc),
    .acc_next  (acc_next)
  );

  // Result of the sum completing this cycle; only captured in DRAIN.
  always_comb begin
    acc_shift = acc_next >>> FracBits;
    acc_wide  = {{(64 - AccWidth){acc_shift[AccWidth-1]}}, acc_shift};
    sat_val   = sat_signed(acc_wide, DataWidth);
`ifdef FC_RELU_EN
    if (sat_val < 0) sat_val = '0;
`else
`endif
  end

  always_comb begin
    state_d    = state_q;
    neuron_d   = neuron_q;
    k_d        = k_q;
    vec_d      = vec_q;
    out_data_d = out_data_q;
    case (state_q)
      StIdle: begin
        if (in_valid) begin
          vec_d    = in_data;
          neuron_d = '0;
          k_d      = '0;
          state_d  = StMac;
        end
      end
      StMac: begin
        if (k_q == KW'(InLen - 1)) begin
          k_d     = '0;
          state_d = StDrain;
        end else begin
          k_d = k_q + KW'(1);
        end
      end
      StDrain: begin
        out_data_d = sat_val[DataWidth-1:0];
        state_d    = StOut;
      end
      StOut: begin
        if (out_ready) begin
          if (neuron_q == NW'(OutLen - 1)) begin
            neuron_d = '0;
            state_d  = StIdle;
          end else begin
            neuron_d = neuron_q + NW'(1);
            state_d  = StMac;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      neuron_q   <= '0;
      k_q        <= '0;
      kd_q       <= '0;
      mac_en_q   <= 1'b0;
      vec_q      <= '0;
      out_data_q <= '0;
    end else begin
      state_q    <= state_d;
      neuron_q   <= neuron_d;
      k_q        <= k_d;
      kd_q       <= k_q;
      mac_en_q   <= (state_q == StMac);
      vec_q      <= vec_d;
      out_data_q <= out_data_d;
    end
  end

  assign mac_addr  = AW'(neuron_q) * AW'(InLen) + AW'(k_q);
  assign in_ready  = (state_q == StIdle);
  assign w_en      = (state_q == StMac);
  assign w_addr    = w_en ? mac_addr : '0;
  assign b_addr    = neuron_q;
  assign out_valid = (state_q == StOut);
  assign out_data  = out_data_q;
  assign out_idx   = neuron_q;
  assign out_last  = (state_q == StOut) && (neuron_q == NW'(OutLen - 1));

  logic unused_bits;
  assign unused_bits = ^{sat_val[63:DataWidth], acc};

endmodule
